// File: rtl/lsu_pkg.sv
// Purpose: shared types and constants for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, access-size codes, and the default geometry.
package lsu_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int DEPTH_WORDS = 256;
  localparam int TAG_W       = 3;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Purpose: byte-lane steering: load extract/extend and byte-store merge.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: i_lane_hi selects [15:8] (1) or [7:0] (0); i_size/i_signed shape the load
//        result o_load_data; o_merged is i_rdata with the selected lane replaced by i_wbyte.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic              i_lane_hi,
  input  logic              i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [7:0]        i_wbyte,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = i_lane_hi ? i_rdata[15:8] : i_rdata[7:0];

    if (i_size == SZ_WORD)
      o_load_data = i_rdata;
    else if (i_signed)
      o_load_data = {{8{w_byte[7]}}, w_byte};
    else
      o_load_data = {8'h00, w_byte};

    // Little-endian lanes: only the addressed byte changes, the other is kept.
    o_merged = i_lane_hi ? {i_wbyte, i_rdata[7:0]} : {i_rdata[15:8], i_wbyte};
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: memory-stage controller; byte/word loads and stores, byte stores via read-modify-write.
// Latency: accept edge to resp_valid: word op 2 cycles, byte store 3, error 1.
// Backpressure: one request in flight; req_ready low until the response is taken on resp_ready.
// Ports: req_* from execute (valid/ready), resp_* to writeback (valid/ready),
//        mem_* to the combinational-read, posedge-write 16-bit data memory.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  lsu_state_t        r_state;
  lsu_state_t        w_state_nxt;
  logic              r_write;
  logic              r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_wbuf;
  logic [DATA_W-1:0] r_resp_data;
  logic [TAG_W-1:0]  r_resp_tag;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_req_err;
  logic              w_byte_store;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  lsu_byte_lane u_byte_lane (
    .i_lane_hi   (r_addr[0]),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_rdata     (mem_rdata),
    .i_wbyte     (r_wdata[7:0]),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  assign req_ready    = (r_state == IDLE) && !rst;
  assign w_accept     = req_valid && req_ready;
  // Misaligned word, or word index past the end of memory.
  assign w_req_err    = ((req_size == SZ_WORD) && req_addr[0]) ||
                        ({1'b0, req_addr[ADDR_W-1:1]} >= DEPTH_L);
  assign w_byte_store = r_write && (r_size == SZ_BYTE);

  assign resp_valid = (r_state == RESP);
  assign resp_data  = r_resp_data;
  assign resp_tag   = r_resp_tag;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_addr;

  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = r_wdata;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (r_write && (r_size == SZ_WORD)) mem_write = 1'b1;
        else                                mem_read  = 1'b1;
        w_state_nxt = w_byte_store ? RMW_WR : RESP;
      end
      RMW_WR: begin
        mem_write   = 1'b1;
        mem_wdata   = r_wbuf;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset must squash a write in flight so memory keeps its old contents.
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_size      <= 1'b0;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tag       <= '0;
      r_wbuf      <= '0;
      r_resp_data <= '0;
      r_resp_tag  <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_tag    <= req_tag;
        // Errors skip memory entirely, so the response is fixed here.
        if (w_req_err) begin
          r_resp_data <= '0;
          r_resp_tag  <= req_tag;
          r_resp_err  <= 1'b1;
        end
      end
      if (r_state == ACCESS) begin
        r_resp_data <= r_write ? '0 : w_load_data;
        r_resp_tag  <= r_tag;
        r_resp_err  <= 1'b0;
        if (w_byte_store) r_wbuf <= w_merged;
      end
    end
  end

endmodule
